// File: rtl/shift_issue_stage.sv
// Registered issue stage feeding the barrel shifter: valid/ready input, 2-entry skid
// buffer (main + skid) on the output, shift-amount selection and a saturating stall counter.
module shift_issue_stage #(
  parameter int DATA_W      = 32,
  parameter int AMT_W       = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_a,
  input  logic [DATA_W-1:0]      in_b,
  input  logic [AMT_W-1:0]       in_shamt,
  input  logic                   in_use_reg,
  input  logic [1:0]             in_type,
  input  logic [4:0]             in_rd,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_a,
  output logic [1:0]             out_type,
  output logic [AMT_W-1:0]       out_amt,
  output logic [4:0]             out_rd,
  output logic                   out_amt_ovf,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [1:0]        typ;
    logic [AMT_W-1:0]  amt;
    logic [4:0]        rd;
    logic              ovf;
  } payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  payload_t               main_q, main_d;
  payload_t               skid_q, skid_d;
  payload_t               in_pl;
  logic                   in_ready_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic                   in_fire;
  logic                   out_fire;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid && in_ready_q;
  assign out_fire  = out_valid && out_ready;

  // Register amounts are truncated modulo DATA_W; any higher bit only raises ovf.
  always_comb begin
    in_pl.a   = in_a;
    in_pl.typ = in_type;
    in_pl.rd  = in_rd;
    if (in_use_reg) begin
      in_pl.amt = in_b[AMT_W-1:0];
      in_pl.ovf = |in_b[DATA_W-1:AMT_W];
    end else begin
      in_pl.amt = in_shamt;
      in_pl.ovf = 1'b0;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_pl;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_pl;
          end else if (in_fire) begin
            skid_d  = in_pl;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
  // NOTE: payload registers are reset too, because the outputs they drive must read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
      main_q     <= main_d;
      skid_q     <= skid_d;
      if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
      end
    end
  end

  assign out_a       = main_q.a;
  assign out_type    = main_q.typ;
  assign out_amt     = main_q.amt;
  assign out_rd      = main_q.rd;
  assign out_amt_ovf = main_q.ovf;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_shift_issue_stage.sv
// Scoreboard bench for shift_issue_stage: the driver pushes expected payloads on accept,
// a negedge monitor pops and compares on every output transfer and checks hold-under-stall.
module tb_shift_issue_stage;

  localparam int DATA_W      = 32;
  localparam int AMT_W       = 5;
  localparam int STALL_CNT_W = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [1:0]  typ;
    logic [4:0]  amt;
    logic [4:0]  rd;
    logic        ovf;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_a = '0;
  logic [DATA_W-1:0]      in_b = '0;
  logic [AMT_W-1:0]       in_shamt = '0;
  logic                   in_use_reg = 1'b0;
  logic [1:0]             in_type = '0;
  logic [4:0]             in_rd = '0;
  logic                   flush = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [DATA_W-1:0]      out_a;
  logic [1:0]             out_type;
  logic [AMT_W-1:0]       out_amt;
  logic [4:0]             out_rd;
  logic                   out_amt_ovf;
  logic [STALL_CNT_W-1:0] stall_cnt;

  int   checks = 0;
  int   failures = 0;
  int   out_xfers = 0;
  int   cycle = 0;
  exp_t exp_q[$];
  logic sent_done;

  shift_issue_stage #(
    .DATA_W(DATA_W), .AMT_W(AMT_W), .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_shamt(in_shamt), .in_use_reg(in_use_reg),
    .in_type(in_type), .in_rd(in_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_type(out_type), .out_amt(out_amt), .out_rd(out_rd),
    .out_amt_ovf(out_amt_ovf), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Offer one op and push its expected output once the DUT accepts it.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] shamt,
                      input logic use_reg, input logic [1:0] typ, input logic [4:0] rd,
                      input logic [4:0] exp_amt, input logic exp_ovf);
    logic rdy;
    exp_t e;
    in_valid = 1'b1; in_a = a; in_b = b; in_shamt = shamt;
    in_use_reg = use_reg; in_type = typ; in_rd = rd;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        e.a = a; e.typ = typ; e.amt = exp_amt; e.rd = rd; e.ovf = exp_ovf;
        exp_q.push_back(e);
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare every output transfer against the scoreboard and check stability under stall.
  initial begin : monitor
    exp_t cur, prev_pl, e;
    logic prev_stall;
    prev_stall = 1'b0;
    prev_pl = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        cur = {out_a, out_type, out_amt, out_rd, out_amt_ovf};
        if (prev_stall) begin
          check("hold_valid", 64'(out_valid), 64'd1);
          check("hold_payload", 64'(cur), 64'(prev_pl));
        end
        if (out_valid && out_ready) begin
          out_xfers++;
          if (exp_q.size() == 0) begin
            check("unexpected_output_rd", 64'(out_rd), 64'h1_0000);
          end else begin
            e = exp_q.pop_front();
            check("out_a", 64'(out_a), 64'(e.a));
            check("out_type", 64'(out_type), 64'(e.typ));
            check("out_amt", 64'(out_amt), 64'(e.amt));
            check("out_rd", 64'(out_rd), 64'(e.rd));
            check("out_amt_ovf", 64'(out_amt_ovf), 64'(e.ovf));
          end
        end
        prev_stall = out_valid && !out_ready && !flush;
        prev_pl = cur;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t0, x0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_payload", 64'({out_a, out_type, out_amt, out_rd, out_amt_ovf}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single op, one-cycle latency.
    out_ready = 1'b1;
    send(32'h8000_00F0, 32'h0, 5'd4, 1'b0, 2'b11, 5'd7, 5'd4, 1'b0);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    check("latency_out_rd", 64'(out_rd), 64'd7);
    drain("drain_single");

    // Amount selection: register amount truncated, overflow flagged; immediate ignores in_b.
    send(32'h0000_1234, 32'h0000_0025, 5'd0, 1'b1, 2'b00, 5'd2, 5'd5,  1'b1);
    send(32'h0000_5678, 32'h0000_001F, 5'd0, 1'b1, 2'b10, 5'd3, 5'd31, 1'b0);
    send(32'hDEAD_BEEF, 32'hFFFF_FFE3, 5'd0, 1'b1, 2'b01, 5'd4, 5'd3,  1'b1);
    send(32'h0F0F_0F0F, 32'hFFFF_FFFF, 5'd9, 1'b0, 2'b10, 5'd5, 5'd9,  1'b0);
    drain("drain_amount");

    // Back-pressure: FULL after two accepts, then in-order release.
    out_ready = 1'b0;
    sent_done = 1'b0;
    fork
      begin
        for (int i = 1; i <= 4; i++)
          send(32'hA000_0000 + i, 32'h0, 5'(i), 1'b0, 2'(i), 5'(i), 5'(i), 1'b0);
        sent_done = 1'b1;
      end
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_out_rd", 64'(out_rd), 64'd1);
    check("full_stall_cnt", 64'(stall_cnt), 64'd2);
    out_ready = 1'b1;
    for (int n = 0; n < 100 && !sent_done; n++) @(posedge clk);
    check("bp_sent_done", 64'(sent_done), 64'd1);
    #1;
    drain("drain_backpressure");

    // Streaming: 10 ops back to back, no gaps, no stalls.
    do_reset();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    t0 = cycle;
    x0 = out_xfers;
    for (int i = 0; i < 10; i++)
      send(32'h1000_0000 + i, 32'h20 + i, 5'(31 - i), i[0], 2'(i), 5'(i + 8),
           i[0] ? 5'(i) : 5'(31 - i), i[0]);
    check("stream_accept_cycles", 64'(cycle - t0), 64'd10);
    @(posedge clk);
    #1;
    check("stream_out_xfers", 64'(out_xfers - x0), 64'd10);
    check("stream_stall_cnt", 64'(stall_cnt), 64'd0);
    drain("drain_stream");

    // Flush in FULL together with an input: both held ops and the new op vanish.
    out_ready = 1'b0;
    send(32'hF100_0000, 32'h0, 5'd1, 1'b0, 2'b00, 5'd10, 5'd1, 1'b0);
    send(32'hF200_0000, 32'h0, 5'd2, 1'b0, 2'b00, 5'd11, 5'd2, 1'b0);
    check("pre_flush_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_a = 32'hF300_0000; in_rd = 5'd12; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(32'hF400_0000, 32'h0, 5'd6, 1'b0, 2'b01, 5'd13, 5'd6, 1'b0);
    drain("drain_flush");

    // Stall counter saturates at all-ones; async reset clears it immediately.
    do_reset();
    out_ready = 1'b0;
    send(32'h5555_AAAA, 32'h0, 5'd3, 1'b0, 2'b10, 5'd20, 5'd3, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("sat_stall_cnt", 64'(stall_cnt), 64'd15);
    check("sat_out_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_stall_cnt", 64'(stall_cnt), 64'd0);
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_reset_out_valid", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Registered issue stage directly upstream of the combinational barrel shifter in the execute path.
- Accepts decoded shift operations from decode/register-read with a valid/ready handshake.
- Selects the shift amount, either the immediate shamt or the low bits of the second register operand.
- Presents registered operand, type and amount to the shifter through a 2-entry skid buffer, giving full throughput under back-pressure. Also counts back-pressure stall cycles.

Parameters:
- DATA_W, 32, operand width (shifter input width)
- AMT_W, 5, shift amount width; must equal log2(DATA_W)
- STALL_CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream has an op
- in_ready  out  1  stage can accept; registered
- in_a  in  DATA_W  operand to be shifted (rs)
- in_b  in  DATA_W  register amount source (rt)
- in_shamt  in  AMT_W  immediate amount
- in_use_reg  in  1  1: amount from in_b, 0: from in_shamt
- in_type  in  2  00 LL, 01 LA, 10 RL, 11 RA
- in_rd  in  5  destination register tag
- flush  in  1  synchronous kill of all held ops
- out_valid  out  1  op presented to shifter
- out_ready  in  1  downstream accepts
- out_a  out  DATA_W  operand to shifter
- out_type  out  2  shift type to shifter
- out_amt  out  AMT_W  shift amount to shifter
- out_rd  out  5  destination tag
- out_amt_ovf  out  1  register amount exceeded DATA_W-1
- stall_cnt  out  STALL_CNT_W  back-pressure cycle count

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, in_ready=1, skid empty, stall_cnt=0.
  - out_a, out_amt, out_type, out_rd and out_amt_ovf are all 0.
  - Deassertion takes effect at the next edge.
- Handshakes:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready.
  - Payload and out_valid must not change while out_valid=1 && out_ready=0.
- Amount selection, at capture:
  - in_use_reg=0: amt=in_shamt, ovf=0.
  - in_use_reg=1: amt=in_b[AMT_W-1:0], ovf = |in_b[DATA_W-1:AMT_W]. The amount is truncated (modulo DATA_W), not saturated.
- Storage: main register (drives outputs) plus one skid register. States by occupancy:
  - EMPTY (main invalid, skid invalid)
  - ONE (main valid, skid invalid)
  - FULL (main valid, skid valid)
- in_ready = (state != FULL), registered from next state.
- Transitions, per edge, with in = input transfer and out = output transfer:
  - EMPTY: in -> ONE (main loaded). Latency is 1 cycle from input transfer to out_valid.
  - ONE: in && out -> ONE (main reloaded from input). in && !out -> FULL (input to skid). !in && out -> EMPTY. Otherwise hold.
  - FULL: out -> ONE (main loaded from skid, skid cleared). No input is accepted in FULL.
- Ordering: strictly in order; skid contents always issue before any later input.
- flush:
  - Highest priority after reset. Next state is EMPTY and in_ready=1 on the next cycle.
  - An input transfer in the same cycle is discarded.
  - An output transfer in the same cycle is still considered taken by downstream.
  - Payload registers may retain stale data but out_valid=0.
  - stall_cnt is not cleared by flush.
- stall_cnt:
  - Increments by 1 each cycle with out_valid && !out_ready.
  - Saturates at all-ones and does not wrap.
  - Cleared only by reset.
- Throughput: one op per cycle when out_ready is held at 1. No bubble when leaving FULL.

Test Plan:
- Reset then single op: a=0x8000_00F0, type=11, in_use_reg=0, shamt=4, rd=7 -> next cycle out_valid=1, out_a=0x8000_00F0, out_amt=4, out_type=11, out_rd=7, ovf=0.
- Register amount: in_use_reg=1, in_b=0x0000_0025 -> out_amt=5, ovf=1. With in_b=0x1F -> out_amt=31, ovf=0.
- Back-pressure: stream 4 ops (rd=1..4) with out_ready=0 -> state reaches FULL after 2 accepts and in_ready=0. Release out_ready -> outputs appear rd=1,2,3,4 in order with no loss or duplicates.
- Streaming: out_ready=1, in_valid=1 for 10 cycles -> 10 consecutive output transfers with no gaps, and stall_cnt stays 0.
- Flush: in FULL assert flush together with in_valid -> next cycle out_valid=0, in_ready=1; the flushed and same-cycle ops never appear at the output.
- Counter saturation: STALL_CNT_W=4, hold out_valid with out_ready=0 for 20 cycles -> stall_cnt=15. Async reset mid-stall -> immediately 0, out_valid=0.
